seq_det_scheduler: RTL and testbench

//  Shares one bit-serial Moore sequence detector (inputs w, synchronous clear; output z) between NREQ

---
 rtl/seq_det_scheduler.sv | 130 +++++++++++++
 tb/tb_seq_det_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_scheduler.sv
// Round-robin front end that time-shares one bit-serial Moore detector among NREQ requesters.
// Each granted word is shifted LSB-first after a detector clear and returns a per-bit match map.
module seq_det_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ack,
  output logic                     det_clr,
  output logic                     det_w,
  input  logic                     det_z,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         done_map,
  output logic [$clog2(WIDTH+1)-1:0] done_count
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(WIDTH+1);
  localparam int BW   = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] map;
  logic [WIDTH-1:0] map_fin;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   rr_ptr;
  logic [BW-1:0]    bitk;
  logic [IDW-1:0]   gid;
  logic             found;

  function automatic logic [CNTW-1:0] popcnt(input logic [WIDTH-1:0] m);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNTW'(m[i]);
    return c;
  endfunction

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    gid   = '0;
    j     = 0;
    for (int off = 0; off < NREQ; off++) begin
      j = int'(rr_ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        gid   = IDW'(j);
      end
    end
  end

  // The last bit's z only arrives during DRAIN, so fold it in on the way out.
  always_comb begin
    map_fin            = map;
    map_fin[WIDTH-1]   = det_z;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word       <= '0;
      map        <= '0;
      id         <= '0;
      rr_ptr     <= '0;
      bitk       <= '0;
      req_ack    <= '0;
      det_clr    <= 1'b0;
      det_w      <= 1'b0;
      done_id    <= '0;
      done_map   <= '0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            word         <= req_data[gid*WIDTH +: WIDTH];
            id           <= gid;
            req_ack      <= '0;
            req_ack[gid] <= 1'b1;
            det_clr      <= 1'b1;
            det_w        <= 1'b0;
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          req_ack <= '0;
          det_clr <= 1'b0;
          det_w   <= word[0];
          bitk    <= '0;
          map     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // Moore output lags by one cycle: z seen now belongs to the previous bit.
          if (bitk != '0) map[bitk - 1'b1] <= det_z;
          if (bitk == BW'(WIDTH-1)) begin
            det_w <= 1'b0;
            state <= DRAIN;
          end else begin
            bitk  <= bitk + 1'b1;
            det_w <= word[bitk + 1'b1];
          end
        end
        DRAIN: begin
          map        <= map_fin;
          done_map   <= map_fin;
          done_count <= popcnt(map_fin);
          done_id    <= id;
          state      <= DONE;
        end
        DONE: begin
          rr_ptr <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: includes a 1?1 Moore detector model, table vectors,
// directed corner sequences and a randomized round-robin scoreboard.
module tb_seq_det_scheduler;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int LAT = WIDTH + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic              det_clr, det_w, det_z;
  logic              busy, done;
  logic [1:0]        done_id;
  logic [WIDTH-1:0]  done_map;
  logic [3:0]        done_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .det_clr(det_clr), .det_w(det_w), .det_z(det_z), .busy(busy), .done(done),
    .done_id(done_id), .done_map(done_map), .done_count(done_count)
  );

  // Detector: z=1 when the last three absorbed bits are 1,?,1 (history since clear).
  logic [2:0] hist = 3'b000;
  always_ff @(posedge clk) begin
    if (det_clr) hist <= 3'b000;
    else         hist <= {hist[1:0], det_w};
  end
  assign det_z = hist[0] & hist[2];

  function automatic logic [WIDTH-1:0] ref_map(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int k = 2; k < WIDTH; k++) m[k] = w[k] & w[k-2];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Waits for the grant of requester 'eid', optionally drops its req, then checks the result.
  task automatic serve(input int eid, input logic [WIDTH-1:0] emap, input int ecnt,
                       input bit drop, input string nm);
    int lat;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ack != '0) break;
    end
    chk({nm, ".ack"}, 32'(req_ack), 32'(1 << eid));
    chk({nm, ".clr"}, 32'(det_clr), 32'd1);
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    if (drop) req[eid] = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'(LAT));
    chk({nm, ".id"}, 32'(done_id), 32'(eid));
    chk({nm, ".map"}, 32'(done_map), 32'(emap));
    chk({nm, ".cnt"}, 32'(done_count), 32'(ecnt));
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".ack"}, 32'(req_ack), 0);
    chk({nm, ".clr"}, 32'(det_clr), 0);
    chk({nm, ".w"}, 32'(det_w), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".id"}, 32'(done_id), 0);
    chk({nm, ".map"}, 32'(done_map), 0);
    chk({nm, ".cnt"}, 32'(done_count), 0);
  endtask

  typedef struct {
    int               id;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] map;
    int               cnt;
  } vec_t;

  vec_t tbl [5];
  logic [WIDTH-1:0] wd [NREQ];
  logic [NREQ-1:0]  pend;
  int mptr, eid;
  int order [5];

  initial begin
    tbl[0] = '{0, 8'h07, 8'b0000_0100, 1};
    tbl[1] = '{2, 8'h05, 8'b0000_0100, 1};
    tbl[2] = '{3, 8'h00, 8'h00, 0};
    tbl[3] = '{1, 8'hFF, 8'b1111_1100, 6};
    tbl[4] = '{2, 8'h01, 8'h00, 0};   // right after FF: clear must flush history
    order  = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle.busy", 32'(busy), 0);

    foreach (tbl[i]) begin
      req_data[tbl[i].id*WIDTH +: WIDTH] = tbl[i].word;
      req[tbl[i].id] = 1'b1;
      serve(tbl[i].id, tbl[i].map, tbl[i].cnt, 1'b1, $sformatf("vec%0d", i));
    end

    // All four held: strict round-robin from a fresh pointer.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wd = '{8'h07, 8'h05, 8'hFF, 8'h0D};
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = wd[i];
    req = 4'b1111;
    for (int g = 0; g < 5; g++)
      serve(order[g], ref_map(wd[order[g]]), $countones(ref_map(wd[order[g]])), 1'b0,
            $sformatf("rr%0d", g));
    req = '0;
    @(negedge clk);

    // Reset in SHIFT cycle 4; pointer would favour req[3] if it survived reset.
    req_data[1*WIDTH +: WIDTH] = 8'h15;
    req[1] = 1'b1;
    serve(1, ref_map(8'h15), $countones(ref_map(8'h15)), 1'b1, "pre");
    @(negedge clk);
    req_data[2*WIDTH +: WIDTH] = 8'hFF;
    req[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ack != '0) break;
    end
    chk("abort.ack", 32'(req_ack), 32'b0100);
    req[2] = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    req_data[1*WIDTH +: WIDTH] = 8'h2D;
    req_data[3*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      chk("midreset.nodone", 32'(done), 0);
    end
    reset_n = 1'b1;
    serve(1, ref_map(8'h2D), $countones(ref_map(8'h2D)), 1'b1, "post1");
    serve(3, ref_map(8'hA5), $countones(ref_map(8'hA5)), 1'b1, "post3");
    req = '0;

    // Randomized traffic against a pending-set / pointer model.
    pend = '0;
    mptr = 0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [NREQ-1:0] add;
      add = (pend == '0) ? NREQ'($urandom_range(1, 15)) : NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        if (add[i] && !pend[i]) begin
          wd[i] = WIDTH'($urandom);
          req_data[i*WIDTH +: WIDTH] = wd[i];
          pend[i] = 1'b1;
        end
      req = pend;
      eid = -1;
      for (int off = 0; off < NREQ; off++)
        if (eid < 0 && pend[(mptr + off) % NREQ]) eid = (mptr + off) % NREQ;
      serve(eid, ref_map(wd[eid]), $countones(ref_map(wd[eid])), 1'b1, $sformatf("rnd%0d", t));
      pend[eid] = 1'b0;
      mptr = (eid + 1) % NREQ;
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
